rc5_decryptor: RTL

- Consumer of the expanded key table S that the key expansion path writes into the S RAM.
- Reads S[t-1] down to S[0] through the same S RAM read port (S_address / S_sub_i) and runs RC5 decryption on one 2-word ciphertext block (A, B).
- Produces the plaintext words.
- Sits beside the key expander. The top level grants it the S RAM port after the expander's done is high.

---
 rtl/rc5_decryptor_if.sv | 24 ++
 rtl/rc5_decryptor.sv | 76 +++++++
 2 files changed

// File: rtl/rc5_decryptor_if.sv
// rc5_decryptor_if: ciphertext request, S RAM read port and plaintext result bundle
interface rc5_decryptor_if #(
  parameter int w = 32,
  parameter int t = 26,
  parameter int t_length = $clog2(t)
);
  logic                start;
  logic [w-1:0]        ct_A;
  logic [w-1:0]        ct_B;
  logic [t_length-1:0] S_address;
  logic [w-1:0]        S_sub_i;
  logic [w-1:0]        pt_A;
  logic [w-1:0]        pt_B;
  logic                busy;
  logic                done;
  modport master (
    output start, ct_A, ct_B, S_sub_i,
    input  S_address, pt_A, pt_B, busy, done
  );
  modport slave (
    input  start, ct_A, ct_B, S_sub_i,
    output S_address, pt_A, pt_B, busy, done
  );
endinterface

// File: rtl/rc5_decryptor.sv
// rc5_decryptor: RC5 block decryption reading the expanded key table S from a synchronous RAM
module rc5_decryptor #(
  parameter int w = 32,
  parameter int t = 26,
  parameter int t_length = $clog2(t),
  parameter int lgw = $clog2(w)
) (
  input logic clk1,
  input logic rst,
  rc5_decryptor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, CALC} state_t;
  state_t state, state_n;
  logic [w-1:0] a, b;
  logic [t_length-1:0] idx, addr;
  logic busy, done;
  function automatic logic [w-1:0] ror(input logic [w-1:0] x, input logic [lgw-1:0] n);
    logic [2*w-1:0] d;
    d = {x, x} >> n;
    return d[w-1:0];
  endfunction
  logic [w-1:0] a_sub, b_sub, a_rnd, b_rnd;
  logic idx_hi_zero, last;
  assign a_sub = a - bus.S_sub_i;
  assign b_sub = b - bus.S_sub_i;
  assign a_rnd = ror(a_sub, b[lgw-1:0]) ^ b;
  assign b_rnd = ror(b_sub, a[lgw-1:0]) ^ a;
  assign idx_hi_zero = idx[t_length-1:1] == '0;
  assign last = idx_hi_zero && !idx[0];
  assign bus.S_address = addr;
  assign bus.pt_A = a;
  assign bus.pt_B = b;
  assign bus.busy = busy;
  assign bus.done = done;
  // state register
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_n;
  // next state: two cycles per S word (address, then compute), leave after S[0]
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? FETCH : IDLE;
      FETCH:   state_n = CALC;
      CALC:    state_n = last ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end
  // datapath: latch block on start, apply one half-round per S word from the top of the table down
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) begin
      a <= '0;
      b <= '0;
      idx <= '0;
      addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a <= bus.ct_A;
      b <= bus.ct_B;
      idx <= t_length'(t - 1);
      addr <= t_length'(t - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == CALC) begin
      if (idx[0]) b <= idx_hi_zero ? b_sub : b_rnd;
      else        a <= idx_hi_zero ? a_sub : a_rnd;
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        idx <= idx - 1'b1;
        addr <= idx - 1'b1;
      end
    end
endmodule
